// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential 4-bit divider.
// Holds the FSM state encoding, the step count and the divide-by-zero quotient.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int         DIV_STEPS = 4;
   localparam logic [3:0] DIV0_QUOT = 4'hF;

endpackage

// File: rtl/full_sub_4_bit.sv
// 4-bit ripple-borrow subtractor: diff = a - b - bin.
// Ports: a, b (minuend/subtrahend), bin (borrow in), diff, bout (borrow out).
module full_sub_4_bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] diff,
   output logic       bout
);

   logic [4:0] br;

   assign br[0] = bin;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign diff[i]  = a[i] ^ b[i] ^ br[i];
      assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
   end

   assign bout = br[4];

endmodule

// File: rtl/seq_div_4_bit.sv
// Multicycle 4-bit unsigned restoring divider, one quotient bit per clock.
// Ports: clk, reset (sync, active-high), start, dividend, divisor ->
//   busy (in CALC), done (1-cycle pulse), quotient, remainder, div_by_zero.
// Option: define SEQ_DIV_EARLY_EXIT_EN to finish at once when dividend < divisor.
module seq_div_4_bit
   import seq_div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   if (WIDTH != 4) begin : g_width_chk
      $error("seq_div_4_bit: WIDTH must be 4");
   end

   div_state_t state, state_n;

   logic [WIDTH-1:0] r, q, d;
   logic [1:0]       cnt;
   logic             dz;

   logic [WIDTH:0]   s;
   logic [WIDTH-1:0] sub_a, sub_b, diff;
   logic             borrow;
   logic             accept;
   logic             take;
   logic             div0;
   logic             last;

   assign s      = {r, q[WIDTH-1]};
   assign accept = s[WIDTH] | ~borrow;
   assign take   = start && (state != CALC);
   assign div0   = (divisor == '0);
   assign last   = (cnt == 2'(DIV_STEPS - 1));

   // Outside CALC the subtractor is idle, so it doubles as the
   // dividend < divisor comparator for the early-exit path.
   assign sub_a = (state == CALC) ? s[WIDTH-1:0] : dividend;
   assign sub_b = (state == CALC) ? d : divisor;

   full_sub_4_bit u_sub (
      .a    (sub_a),
      .b    (sub_b),
      .bin  (1'b0),
      .diff (diff),
      .bout (borrow)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (start) begin
               if (div0)        state_n = DONE;
`ifdef SEQ_DIV_EARLY_EXIT_EN
               else if (borrow) state_n = DONE;
`endif
               else             state_n = CALC;
            end
         end
         CALC:    if (last) state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r   <= '0;
         q   <= '0;
         d   <= '0;
         cnt <= '0;
         dz  <= 1'b0;
      end else if (take) begin
         d   <= divisor;
         cnt <= '0;
         dz  <= div0;
         if (div0) begin
            q <= DIV0_QUOT;
            r <= dividend;
`ifdef SEQ_DIV_EARLY_EXIT_EN
         end else if (borrow) begin
            q <= '0;
            r <= dividend;
`endif
         end else begin
            q <= dividend;
            r <= '0;
         end
      end else if (state == CALC) begin
         r   <= accept ? diff : s[WIDTH-1:0];
         q   <= {q[WIDTH-2:0], accept};
         cnt <= cnt + 2'd1;
      end
   end

   assign busy        = (state == CALC);
   assign done        = (state == DONE);
   assign quotient    = q;
   assign remainder   = r;
   assign div_by_zero = dz;

endmodule

// File: tb/tb_seq_div_4_bit.sv
// Self-checking bench for seq_div_4_bit: directed cases plus random
// operands checked against plain integer division.
module tb_seq_div_4_bit;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] dividend, divisor;
   logic       busy, done, div_by_zero;
   logic [3:0] quotient, remainder;

   int vectors = 0;
   int errs    = 0;

   seq_div_4_bit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input int a, input int b);
      if (b == 0) return 1;
`ifdef SEQ_DIV_EARLY_EXIT_EN
      if (a < b) return 1;
`endif
      return 5;
   endfunction

   task automatic chk_res(input int a, input int b);
      if (b == 0) begin
         chk("quot", quotient, 15);
         chk("rem", remainder, a);
         chk("dz", div_by_zero, 1);
      end else begin
         chk("quot", quotient, a / b);
         chk("rem", remainder, a % b);
         chk("dz", div_by_zero, 0);
      end
   endtask

   // Launch one op, scramble inputs after acceptance, walk its latency.
   task automatic do_op(input int a, input int b);
      int lat;
      lat = exp_lat(a, b);
      @(negedge clk);
      start = 1'b1; dividend = 4'(a); divisor = 4'(b);
      @(posedge clk); #1;
      start = 1'b0;
      dividend = 4'($urandom); divisor = 4'($urandom);
      for (int c = 1; c <= lat; c++) begin
         chk("busy", busy, (c < lat) ? 1 : 0);
         chk("done", done, (c == lat) ? 1 : 0);
         if (c < lat) begin
            @(posedge clk); #1;
         end
      end
      chk_res(a, b);
      @(posedge clk); #1;
      chk("done_clr", done, 0);
      chk_res(a, b);
   endtask

   initial begin
      int a, b;
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quot", quotient, 0);
      chk("rst_rem", remainder, 0);
      chk("rst_dz", div_by_zero, 0);
      reset = 1'b0;

      do_op(13, 3);
      do_op(15, 1);
      do_op(15, 15);
      do_op(7, 0);
      do_op(9, 2);
      do_op(2, 9);

      // start held through the op: ignored in CALC, relaunches in DONE
      @(negedge clk);
      start = 1'b1; dividend = 4'd14; divisor = 4'd4;
      @(posedge clk); #1;
      dividend = 4'd7; divisor = 4'd7;
      for (int c = 1; c <= 10; c++) begin
         if (c == 4) begin
            dividend = 4'd14; divisor = 4'd4;
         end
         if (c == 6) start = 1'b0;
         chk("hs_busy", busy, (c != 5 && c != 10) ? 1 : 0);
         chk("hs_done", done, (c == 5 || c == 10) ? 1 : 0);
         if (c == 5 || c == 10) begin
            chk("hs_quot", quotient, 3);
            chk("hs_rem", remainder, 2);
         end
         if (c < 10) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      chk("hs_idle", done, 0);

      // reset asserted in cycle 3 of 12 / 5
      @(negedge clk);
      start = 1'b1; dividend = 4'd12; divisor = 4'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_quot", quotient, 0);
      chk("mr_rem", remainder, 0);
      chk("mr_dz", div_by_zero, 0);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("mr_nodone", done, 0);
      end
      do_op(12, 5);

      for (int n = 0; n < 40; n++) begin
         a = int'($urandom_range(0, 15));
         b = (n % 8 == 0) ? 0 : int'($urandom_range(0, 15));
         do_op(a, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
